parpadeo_ctrl: RTL and testbench

- Edit-mode controller for the HH:MM:SS display during time setting.
- Sequences which digit pair blinks, generates the blink phase internally on `clk` with a cycle-count enable (no derived clock), and routes debounced button pulses to the selected field as inc/dec strobes.
- Returns to normal display on confirm, or aborts after an inactivity timeout.
- Sits between the button debouncers and the time-counter/7-segment mux.

---
 rtl/parpadeo_pkg.sv | 57 +++++
 rtl/parpadeo_timer.sv | 42 ++++
 rtl/parpadeo_ctrl.sv | 116 +++++++++++
 tb/tb_parpadeo_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/parpadeo_pkg.sv
// rtl/parpadeo_pkg.sv - shared state, field and blank-mask definitions for the edit-mode controller
package parpadeo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2,
    ST_EDIT_S = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  localparam int HR_LSB  = 4;
  localparam int MIN_LSB = 2;
  localparam int SEC_LSB = 0;

  // Field code shown on field_sel for a given controller state
  function automatic logic [1:0] field_of(state_t s);
    logic [1:0] f;
    case (s)
      ST_EDIT_H: f = FIELD_H;
      ST_EDIT_M: f = FIELD_M;
      ST_EDIT_S: f = FIELD_S;
      default:   f = FIELD_NONE;
    endcase
    return f;
  endfunction

  // btn_set walks hours -> minutes -> seconds -> back to normal display
  function automatic state_t next_field(state_t s);
    state_t n;
    case (s)
      ST_IDLE:   n = ST_EDIT_H;
      ST_EDIT_H: n = ST_EDIT_M;
      ST_EDIT_M: n = ST_EDIT_S;
      default:   n = ST_IDLE;
    endcase
    return n;
  endfunction

  // Only the selected digit pair blinks; everything else stays lit
  function automatic logic [5:0] mask_of(logic [1:0] f, logic phase_on);
    logic [5:0] m;
    m = '0;
    case (f)
      FIELD_H: m[HR_LSB  +: 2] = {2{~phase_on}};
      FIELD_M: m[MIN_LSB +: 2] = {2{~phase_on}};
      FIELD_S: m[SEC_LSB +: 2] = {2{~phase_on}};
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/parpadeo_timer.sv
// rtl/parpadeo_timer.sv - blink phase counter running on clk with restart and run controls
module parpadeo_timer #(
  parameter int BLINK_PERIOD = 25000000,
  parameter int BLINK_ON     = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic phase_on,
  output logic wrap
);

  localparam int CW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CW-1:0] LAST   = CW'(BLINK_PERIOD - 1);
  localparam logic [CW-1:0] ON_LIM = CW'(BLINK_ON);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // Counter sits at 0 when idle or restarted so the field is solid right after user action
  always_comb begin
    cnt_nx = '0;
    if (run && !restart && (cnt != LAST)) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  // phase_on is registered from the next count so it always describes the current cnt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      phase_on <= (ON_LIM != '0);
    end else begin
      cnt      <= cnt_nx;
      phase_on <= (cnt_nx < ON_LIM);
    end
  end

  assign wrap = run && (cnt == LAST);

endmodule

// File: rtl/parpadeo_ctrl.sv
// rtl/parpadeo_ctrl.sv - edit-mode FSM selecting the blinking field and routing inc/dec strobes
module parpadeo_ctrl
  import parpadeo_pkg::*;
#(
  parameter int BLINK_PERIOD   = 25000000,
  parameter int BLINK_ON       = 12500000,
  parameter int TIMEOUT_BLINKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_set,
  input  logic       btn_ok,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       edit_active,
  output logic [1:0] field_sel,
  output logic [5:0] blank_mask,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       commit,
  output logic       abort
);

  localparam int TW = $clog2(TIMEOUT_BLINKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BLINKS - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_BLINKS);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] to_cnt;
  logic          run;
  logic          restart;
  logic          phase_on;
  logic          wrap;
  logic          timeout;
  logic          any_btn;
  logic          inc_nx;
  logic          dec_nx;
  logic          commit_nx;
  logic          abort_nx;

  assign run     = (state != ST_IDLE);
  assign any_btn = btn_set | btn_ok | btn_inc | btn_dec;
  // Timeout fires on the wrap that completes the last quiet period, so abort lands on that boundary
  assign timeout = wrap && (to_cnt >= TO_LAST);

  // Next state and strobes, resolving ok > set > timeout > inc/dec
  always_comb begin
    state_nx  = state;
    inc_nx    = 1'b0;
    dec_nx    = 1'b0;
    commit_nx = 1'b0;
    abort_nx  = 1'b0;
    if (state == ST_IDLE) begin
      if (btn_set) begin
        state_nx = ST_EDIT_H;
      end
    end else if (btn_ok) begin
      state_nx  = ST_IDLE;
      commit_nx = 1'b1;
    end else if (btn_set) begin
      state_nx  = next_field(state);
      commit_nx = (state == ST_EDIT_S);
    end else if (timeout) begin
      state_nx = ST_IDLE;
      abort_nx = 1'b1;
    end else if (btn_inc ^ btn_dec) begin
      inc_nx = btn_inc;
      dec_nx = btn_dec;
    end
  end

  assign restart = (state_nx != state) || inc_nx || dec_nx;

  parpadeo_timer #(
    .BLINK_PERIOD (BLINK_PERIOD),
    .BLINK_ON     (BLINK_ON)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .run      (run),
    .phase_on (phase_on),
    .wrap     (wrap)
  );

  // State, registered outputs and the saturating quiet-period counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      edit_active <= 1'b0;
      field_sel   <= FIELD_NONE;
      inc_pulse   <= 1'b0;
      dec_pulse   <= 1'b0;
      commit      <= 1'b0;
      abort       <= 1'b0;
      to_cnt      <= '0;
    end else begin
      state       <= state_nx;
      edit_active <= (state_nx != ST_IDLE);
      field_sel   <= field_of(state_nx);
      inc_pulse   <= inc_nx;
      dec_pulse   <= dec_nx;
      commit      <= commit_nx;
      abort       <= abort_nx;
      if (!run || (state_nx != state) || any_btn) begin
        to_cnt <= '0;
      end else if (wrap && (to_cnt != TO_MAX)) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign blank_mask = mask_of(field_sel, phase_on);

endmodule

// File: tb/tb_parpadeo_ctrl.sv
// tb/tb_parpadeo_ctrl.sv - directed and randomized self-checking bench for parpadeo_ctrl
module tb_parpadeo_ctrl;

  localparam int P  = 8;
  localparam int ON = 4;
  localparam int T  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_set;
  logic       btn_ok;
  logic       btn_inc;
  logic       btn_dec;
  logic       edit_active;
  logic [1:0] field_sel;
  logic [5:0] blank_mask;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       commit;
  logic       abort;

  int tests  = 0;
  int failed = 0;

  // Reference model: field number, cycles since blink restart, completed quiet periods
  int   m_field = 0;
  int   m_age   = 0;
  int   m_quiet = 0;
  logic e_inc, e_dec, e_commit, e_abort;

  always #5 clk = ~clk;

  parpadeo_ctrl #(
    .BLINK_PERIOD   (P),
    .BLINK_ON       (ON),
    .TIMEOUT_BLINKS (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_set     (btn_set),
    .btn_ok      (btn_ok),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .edit_active (edit_active),
    .field_sel   (field_sel),
    .blank_mask  (blank_mask),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .commit      (commit),
    .abort       (abort)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_mask();
    logic [5:0] m;
    m = '0;
    if (m_field != 0 && (m_age % P) >= ON) begin
      m = 6'b000011 << (2 * (3 - m_field));
    end
    return m;
  endfunction

  task automatic model(input logic s, input logic o, input logic i, input logic d, input logic r);
    int  nf;
    bit  period_done;
    bit  rst_blink;
    e_inc = 0; e_dec = 0; e_commit = 0; e_abort = 0;
    if (!r) begin
      m_field = 0; m_age = 0; m_quiet = 0;
      return;
    end
    nf          = m_field;
    rst_blink   = 0;
    period_done = (m_field != 0) && ((m_age % P) == P - 1);
    if (m_field == 0) begin
      if (s) nf = 1;
    end else if (o) begin
      nf = 0; e_commit = 1;
    end else if (s) begin
      nf = (m_field == 3) ? 0 : m_field + 1;
      e_commit = (m_field == 3);
    end else if (period_done && (m_quiet + 1 >= T)) begin
      nf = 0; e_abort = 1;
    end else if (i != d) begin
      e_inc = i; e_dec = d; rst_blink = 1;
    end
    if (nf != m_field || nf == 0 || s || o || i || d) m_quiet = 0;
    else if (period_done) m_quiet++;
    if (nf != m_field || nf == 0 || rst_blink) m_age = 0;
    else m_age++;
    m_field = nf;
  endtask

  task automatic step(input logic s, input logic o, input logic i, input logic d, input logic r);
    btn_set = s; btn_ok = o; btn_inc = i; btn_dec = d; rst_n = r;
    model(s, o, i, d, r);
    @(posedge clk);
    #1;
    chk("edit_active", {7'b0, edit_active}, {7'b0, m_field != 0});
    chk("field_sel",   {6'b0, field_sel},   8'(m_field));
    chk("blank_mask",  {2'b0, blank_mask},  {2'b0, exp_mask()});
    chk("inc_pulse",   {7'b0, inc_pulse},   {7'b0, e_inc});
    chk("dec_pulse",   {7'b0, dec_pulse},   {7'b0, e_dec});
    chk("commit",      {7'b0, commit},      {7'b0, e_commit});
    chk("abort",       {7'b0, abort},       {7'b0, e_abort});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    int lat;
    int dens [3];
    dens[0] = 4; dens[1] = 30; dens[2] = 150;
    btn_set = 0; btn_ok = 0; btn_inc = 0; btn_dec = 0; rst_n = 0;

    // reset state
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    // ok / inc / dec ignored in IDLE
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    idle(3);
    // enter EDIT_H and watch two blink periods
    step(1, 0, 0, 0, 1);
    idle(16);
    // walk hours -> minutes -> seconds -> commit
    step(1, 0, 0, 0, 1); idle(9);
    step(1, 0, 0, 0, 1); idle(9);
    step(1, 0, 0, 0, 1); idle(3);
    // EDIT_M: inc at blink position 6, then inc+dec together, then dec
    step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1);
    idle(6);
    chk("mask_at_pos6", {2'b0, blank_mask}, 8'h0c);
    step(0, 0, 1, 0, 1);
    chk("mask_after_inc", {2'b0, blank_mask}, 8'h00);
    idle(2);
    step(0, 0, 1, 1, 1);
    idle(5);
    step(0, 0, 0, 1, 1);
    idle(2);
    step(0, 1, 0, 0, 1);
    // EDIT_S left alone until timeout
    step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, 0, 1);
      if (abort === 1'b1 && lat == 0) lat = k;
    end
    chk("abort_latency", 8'(lat), 8'd24);
    // ok and set together in EDIT_H
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    idle(2);
    // reset in the middle of EDIT_M
    step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 1); idle(3);
    step(0, 0, 0, 0, 0);
    idle(2);
    // set and ok colliding with the timeout cycle
    step(1, 0, 0, 0, 1); idle(23);
    step(1, 0, 0, 0, 1);
    idle(23);
    step(0, 1, 0, 0, 1);
    idle(2);
    // randomized traffic at three activity densities
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 1500; k++) begin
        step($urandom_range(0, dens[g] * 3) == 0,
             $urandom_range(0, dens[g] * 6) == 0,
             $urandom_range(0, dens[g]) == 0,
             $urandom_range(0, dens[g]) == 0,
             $urandom_range(0, 400) != 0);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
